apb_slave_mem: RTL and testbench

//  APB completer (slave) backed by a DEPTH x DATA_W register array: the responder end of the
//  APB bridge driven by PCLK/PRST. The bridge decodes bus-address bit 8 into PSEL, so two

---
 rtl/apb_slave_mem_pkg.sv | 22 ++
 rtl/apb_slave_mem_regfile.sv | 42 ++++
 rtl/apb_slave_mem.sv | 139 +++++++++++++
 tb/tb_apb_slave_mem.sv | 322 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/apb_slave_mem_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | apb_slave_mem_pkg : shared APB completer encodings and default widths      |
// | Revision 1.0                                                               |
// +----------------------------------------------------------------------------+
package apb_slave_mem_pkg;

  localparam int unsigned APB_ADDR_W = 8;
  localparam int unsigned APB_DATA_W = 8;
  localparam int unsigned APB_CNT_W  = 4;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_WAIT = 2'd1;
  localparam logic [1:0] ST_ACK  = 2'd2;

  function automatic logic addr_out_of_range(input logic [31:0] addr,
                                             input logic [31:0] depth);
    return (addr >= depth);
  endfunction

endpackage
`default_nettype wire

// File: rtl/apb_slave_mem_regfile.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | apb_slave_mem_regfile : DEPTH x DATA_W array, sync write, registered read  |
// | Revision 1.0                                                               |
// +----------------------------------------------------------------------------+
module apb_slave_mem_regfile #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned DEPTH  = 256,
  parameter int unsigned IDX_W  = 8
) (
  input  logic              clk_i,
  input  logic              clr_i,
  input  logic              we_i,
  input  logic [IDX_W-1:0]  waddr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic              re_i,
  input  logic [IDX_W-1:0]  raddr_i,
  output logic [DATA_W-1:0] rdata_o
);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] rdata_q;

  // Storage is deliberately left out of reset.
  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (clr_i) begin
      rdata_q <= '0;
    end else if (re_i) begin
      rdata_q <= mem_q[raddr_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule
`default_nettype wire

// File: rtl/apb_slave_mem.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | apb_slave_mem : APB completer with fixed wait states and range-error flag  |
// | Revision 1.0                                                               |
// +----------------------------------------------------------------------------+
module apb_slave_mem
  import apb_slave_mem_pkg::*;
#(
  parameter int unsigned ADDR_W      = APB_ADDR_W,
  parameter int unsigned DATA_W      = APB_DATA_W,
  parameter int unsigned DEPTH       = 256,
  parameter int unsigned WAIT_STATES = 0
) (
  input  logic              PCLK,
  input  logic              PRST,
  input  logic              PSEL,
  input  logic              PENABLE,
  input  logic              PWRITE,
  input  logic [ADDR_W-1:0] PADDR,
  input  logic [DATA_W-1:0] PWDATA,
  output logic [DATA_W-1:0] PRDATA,
  output logic              PREADY,
  output logic              PSLVERR
);

  localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [APB_CNT_W-1:0] CNT_INIT =
    (WAIT_STATES > 0) ? APB_CNT_W'(WAIT_STATES - 1) : '0;

  logic [1:0]           state_q,   state_d;
  logic [APB_CNT_W-1:0] cnt_q,     cnt_d;
  logic [ADDR_W-1:0]    addr_q,    addr_d;
  logic [DATA_W-1:0]    wdata_q,   wdata_d;
  logic                 write_q,   write_d;
  logic                 err_q,     err_d;
  logic                 pready_q,  pready_d;
  logic                 pslverr_q, pslverr_d;

  logic              enter_ack;
  logic              rf_we;
  logic              rf_re;
  logic              rf_clr;
  logic [DATA_W-1:0] rf_rdata;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    write_d = write_q;
    err_d   = err_q;
    case (state_q)
      ST_IDLE: begin
        // PSEL with PENABLE already high is not a valid setup and is ignored.
        if (PSEL && !PENABLE) begin
          addr_d  = PADDR;
          wdata_d = PWDATA;
          write_d = PWRITE;
          err_d   = addr_out_of_range(32'(PADDR), 32'(DEPTH));
          if (WAIT_STATES > 0) begin
            state_d = ST_WAIT;
            cnt_d   = CNT_INIT;
          end else begin
            state_d = ST_ACK;
          end
        end
      end
      ST_WAIT: begin
        if (!PSEL) begin
          state_d = ST_IDLE;
        end else if (cnt_q == '0) begin
          state_d = ST_ACK;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      ST_ACK: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // The read port is addressed with the next-cycle capture so a zero-wait
  // read can load PRDATA on the same edge that latches the setup address.
  always_comb begin
    enter_ack = (state_d == ST_ACK) && (state_q != ST_ACK);
    pready_d  = (state_d == ST_ACK);
    pslverr_d = (state_d == ST_ACK) && err_d;
    rf_re     = enter_ack && !write_d && !err_d && !PRST;
    rf_clr    = PRST || (enter_ack && !write_d && err_d);
    rf_we     = (state_q == ST_ACK) && PSEL && PENABLE && write_q && !err_q && !PRST;
  end

  always_ff @(posedge PCLK) begin
    if (PRST) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      addr_q    <= '0;
      wdata_q   <= '0;
      write_q   <= 1'b0;
      err_q     <= 1'b0;
      pready_q  <= 1'b0;
      pslverr_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      write_q   <= write_d;
      err_q     <= err_d;
      pready_q  <= pready_d;
      pslverr_q <= pslverr_d;
    end
  end

  apb_slave_mem_regfile #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .IDX_W  (IDX_W)
  ) u_regfile (
    .clk_i   (PCLK),
    .clr_i   (rf_clr),
    .we_i    (rf_we),
    .waddr_i (addr_q[IDX_W-1:0]),
    .wdata_i (wdata_q),
    .re_i    (rf_re),
    .raddr_i (addr_d[IDX_W-1:0]),
    .rdata_o (rf_rdata)
  );

  assign PRDATA  = rf_rdata;
  assign PREADY  = pready_q;
  assign PSLVERR = pslverr_q;

endmodule
`default_nettype wire

// File: tb/tb_apb_slave_mem.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_apb_slave_mem : three differently configured completers vs. array model |
// | Revision 1.0                                                               |
// +----------------------------------------------------------------------------+
module tb_apb_slave_mem;

  logic       clk = 1'b0;
  logic       rst;
  logic       psel    [3];
  logic       penable [3];
  logic       pwrite  [3];
  logic [7:0] paddr   [3];
  logic [7:0] pwdata  [3];
  logic [7:0] prdata  [3];
  logic       pready  [3];
  logic       pslverr [3];

  int compared   = 0;
  int mismatched = 0;

  // Reference: per instance its configuration, word array and last PRDATA.
  int         ws_m    [3];
  int         depth_m [3];
  logic [7:0] mem_m   [3][256];
  logic [7:0] prd_m   [3];

  always #5 clk = ~clk;

  apb_slave_mem #(.ADDR_W(8), .DATA_W(8), .DEPTH(256), .WAIT_STATES(0)) u_dut0 (
    .PCLK(clk), .PRST(rst), .PSEL(psel[0]), .PENABLE(penable[0]), .PWRITE(pwrite[0]),
    .PADDR(paddr[0]), .PWDATA(pwdata[0]), .PRDATA(prdata[0]), .PREADY(pready[0]),
    .PSLVERR(pslverr[0]));

  apb_slave_mem #(.ADDR_W(8), .DATA_W(8), .DEPTH(128), .WAIT_STATES(2)) u_dut1 (
    .PCLK(clk), .PRST(rst), .PSEL(psel[1]), .PENABLE(penable[1]), .PWRITE(pwrite[1]),
    .PADDR(paddr[1]), .PWDATA(pwdata[1]), .PRDATA(prdata[1]), .PREADY(pready[1]),
    .PSLVERR(pslverr[1]));

  apb_slave_mem #(.ADDR_W(8), .DATA_W(8), .DEPTH(256), .WAIT_STATES(3)) u_dut2 (
    .PCLK(clk), .PRST(rst), .PSEL(psel[2]), .PENABLE(penable[2]), .PWRITE(pwrite[2]),
    .PADDR(paddr[2]), .PWDATA(pwdata[2]), .PRDATA(prdata[2]), .PREADY(pready[2]),
    .PSLVERR(pslverr[2]));

  function automatic void model_xfer(input int k, input bit wr, input logic [7:0] a,
                                     input logic [7:0] d, output logic [7:0] exp_rd,
                                     output logic exp_err);
    exp_err = (int'(a) >= depth_m[k]);
    if (wr) begin
      exp_rd = prd_m[k];
      if (!exp_err) mem_m[k][a] = d;
    end else begin
      exp_rd   = exp_err ? 8'h00 : mem_m[k][a];
      prd_m[k] = exp_rd;
    end
  endfunction

  // One complete transfer; starts and ends on a falling edge, bus released after.
  task automatic xfer(input int k, input bit wr, input logic [7:0] a, input logic [7:0] d,
                      output int waits, output logic [7:0] rd_first, output logic [7:0] rd,
                      output logic er, output logic rdy_after, output logic er_after,
                      output logic [7:0] rd_after);
    psel[k] = 1'b1; penable[k] = 1'b0; pwrite[k] = wr; paddr[k] = a; pwdata[k] = d;
    @(negedge clk);
    penable[k] = 1'b1;
    paddr[k]   = 8'($urandom);
    pwdata[k]  = 8'($urandom);
    rd_first   = prdata[k];
    waits      = 0;
    while (pready[k] !== 1'b1 && waits < 20) begin
      @(negedge clk);
      waits++;
    end
    rd = prdata[k];
    er = pslverr[k];
    @(negedge clk);
    rdy_after = pready[k];
    er_after  = pslverr[k];
    rd_after  = prdata[k];
    psel[k] = 1'b0; penable[k] = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    for (int k = 0; k < 3; k++) begin
      psel[k] = 1'b0; penable[k] = 1'b0; pwrite[k] = 1'b0; paddr[k] = '0; pwdata[k] = '0;
    end
    repeat (3) @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      compared++;
      if (pready[k] !== 1'b0 || pslverr[k] !== 1'b0 || prdata[k] !== 8'h00) begin
        mismatched++;
        $display("FAIL reset[%0d]: ready=%b err=%b rdata=%h, want 0 0 00",
                 k, pready[k], pslverr[k], prdata[k]);
      end
      prd_m[k] = 8'h00;
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_fill();
    int w; logic [7:0] rf, rd, rda, xr, d; logic er, ra, ea, xe;
    for (int k = 0; k < 3; k++) begin
      for (int a = 0; a < depth_m[k]; a++) begin
        d = 8'($urandom);
        model_xfer(k, 1'b1, 8'(a), d, xr, xe);
        xfer(k, 1'b1, 8'(a), d, w, rf, rd, er, ra, ea, rda);
        compared++;
        if (w !== ws_m[k] || er !== xe || rd !== xr) begin
          mismatched++;
          $display("FAIL fill[%0d][%0d]: waits=%0d err=%b rdata=%h, want %0d %b %h",
                   k, a, w, er, rd, ws_m[k], xe, xr);
        end
      end
    end
  endtask

  task automatic test_basic();
    int w; logic [7:0] rf, rd, rda, xr; logic er, ra, ea, xe;
    for (int i = 0; i < 2; i++) begin
      model_xfer(0, (i == 0), 8'h3F, 8'h18, xr, xe);
      xfer(0, (i == 0), 8'h3F, 8'h18, w, rf, rd, er, ra, ea, rda);
      compared++;
      if (w !== 0 || er !== 1'b0 || rd !== xr || (i == 1 && rd !== 8'h18)) begin
        mismatched++;
        $display("FAIL basic[%0d]: waits=%0d err=%b rdata=%h, want 0 0 %h", i, w, er, rd, xr);
      end
      compared++;
      if (ra !== 1'b0 || ea !== 1'b0 || rda !== xr) begin
        mismatched++;
        $display("FAIL basic_post[%0d]: ready=%b err=%b rdata=%h, want 0 0 %h", i, ra, ea, rda, xr);
      end
    end
  endtask

  task automatic test_wait_states();
    int w; logic [7:0] rf, rd, rda, xr, prev; logic er, ra, ea, xe;
    for (int k = 1; k < 3; k++) begin
      for (int i = 0; i < 2; i++) begin
        prev = prd_m[k];
        model_xfer(k, (i == 0), 8'h3F, 8'h18, xr, xe);
        xfer(k, (i == 0), 8'h3F, 8'h18, w, rf, rd, er, ra, ea, rda);
        compared++;
        if (w !== ws_m[k] || er !== xe || rd !== xr || rf !== prev) begin
          mismatched++;
          $display("FAIL wait[%0d][%0d]: waits=%0d err=%b rdata=%h early=%h, want %0d %b %h %h",
                   k, i, w, er, rd, rf, ws_m[k], xe, xr, prev);
        end
        compared++;
        if (ra !== 1'b0 || ea !== 1'b0 || rda !== xr) begin
          mismatched++;
          $display("FAIL wait_post[%0d][%0d]: ready=%b err=%b rdata=%h, want 0 0 %h",
                   k, i, ra, ea, rda, xr);
        end
      end
    end
  endtask

  task automatic test_error();
    int w; logic [7:0] rf, rd, rda, xr; logic er, ra, ea, xe;
    logic [7:0] ad [3] = '{8'hC8, 8'hC8, 8'h48};
    bit         wr [3] = '{1'b1, 1'b0, 1'b0};
    for (int i = 0; i < 3; i++) begin
      model_xfer(1, wr[i], ad[i], 8'h55, xr, xe);
      xfer(1, wr[i], ad[i], 8'h55, w, rf, rd, er, ra, ea, rda);
      compared++;
      if (w !== ws_m[1] || er !== xe || rd !== xr) begin
        mismatched++;
        $display("FAIL error[%0d]: waits=%0d err=%b rdata=%h, want %0d %b %h",
                 i, w, er, rd, ws_m[1], xe, xr);
      end
      compared++;
      if (ra !== 1'b0 || ea !== 1'b0 || rda !== xr) begin
        mismatched++;
        $display("FAIL error_post[%0d]: ready=%b err=%b rdata=%h, want 0 0 %h", i, ra, ea, rda, xr);
      end
    end
  endtask

  task automatic test_abort();
    int w; logic [7:0] rf, rd, rda, xr; logic er, ra, ea, xe;
    psel[2] = 1'b1; penable[2] = 1'b0; pwrite[2] = 1'b1; paddr[2] = 8'h10; pwdata[2] = 8'hAA;
    @(negedge clk);
    penable[2] = 1'b1;
    @(negedge clk);
    psel[2] = 1'b0; penable[2] = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      compared++;
      if (pready[2] !== 1'b0) begin
        mismatched++;
        $display("FAIL abort_ready[%0d]: ready=%b, want 0", i, pready[2]);
      end
    end
    model_xfer(2, 1'b0, 8'h10, 8'h00, xr, xe);
    xfer(2, 1'b0, 8'h10, 8'h00, w, rf, rd, er, ra, ea, rda);
    compared++;
    if (w !== ws_m[2] || er !== xe || rd !== xr) begin
      mismatched++;
      $display("FAIL abort_read: waits=%0d err=%b rdata=%h, want %0d %b %h", w, er, rd, ws_m[2], xe, xr);
    end
  endtask

  task automatic test_reset_mid();
    int w; logic [7:0] rf, rd, rda, xr; logic er, ra, ea, xe;
    model_xfer(2, 1'b1, 8'h21, 8'h5A, xr, xe);
    xfer(2, 1'b1, 8'h21, 8'h5A, w, rf, rd, er, ra, ea, rda);
    model_xfer(2, 1'b0, 8'h21, 8'h00, xr, xe);
    xfer(2, 1'b0, 8'h21, 8'h00, w, rf, rd, er, ra, ea, rda);
    compared++;
    if (rd !== 8'h5A) begin
      mismatched++;
      $display("FAIL rstmid_pre: rdata=%h, want 5a", rd);
    end
    psel[2] = 1'b1; penable[2] = 1'b0; pwrite[2] = 1'b1; paddr[2] = 8'h20; pwdata[2] = 8'h77;
    @(negedge clk);
    penable[2] = 1'b1;
    @(negedge clk);
    rst = 1'b1; psel[2] = 1'b0; penable[2] = 1'b0;
    @(negedge clk);
    compared++;
    if (pready[2] !== 1'b0 || pslverr[2] !== 1'b0 || prdata[2] !== 8'h00) begin
      mismatched++;
      $display("FAIL rstmid: ready=%b err=%b rdata=%h, want 0 0 00", pready[2], pslverr[2], prdata[2]);
    end
    rst = 1'b0;
    for (int k = 0; k < 3; k++) prd_m[k] = 8'h00;
    @(negedge clk);
    model_xfer(2, 1'b0, 8'h20, 8'h00, xr, xe);
    xfer(2, 1'b0, 8'h20, 8'h00, w, rf, rd, er, ra, ea, rda);
    compared++;
    if (w !== ws_m[2] || er !== xe || rd !== xr) begin
      mismatched++;
      $display("FAIL rstmid_read: waits=%0d err=%b rdata=%h, want %0d %b %h", w, er, rd, ws_m[2], xe, xr);
    end
  endtask

  task automatic test_back_to_back();
    int w; logic [7:0] rf, rd, rda, xr; logic er, ra, ea, xe;
    for (int i = 0; i < 16; i++) begin
      model_xfer(0, (i < 8), 8'(i % 8), 8'(2 * (i % 8)), xr, xe);
      xfer(0, (i < 8), 8'(i % 8), 8'(2 * (i % 8)), w, rf, rd, er, ra, ea, rda);
      compared++;
      if (w !== 0 || er !== xe || rd !== xr || (i >= 8 && rd !== 8'(2 * (i - 8)))) begin
        mismatched++;
        $display("FAIL b2b[%0d]: waits=%0d err=%b rdata=%h, want 0 %b %h", i, w, er, rd, xe, xr);
      end
      compared++;
      if (ra !== 1'b0) begin
        mismatched++;
        $display("FAIL b2b_width[%0d]: ready after ack=%b, want 0", i, ra);
      end
    end
    psel[0] = 1'b1; penable[0] = 1'b1; pwrite[0] = 1'b1; paddr[0] = 8'h00; pwdata[0] = 8'hFF;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      compared++;
      if (pready[0] !== 1'b0) begin
        mismatched++;
        $display("FAIL nosetup[%0d]: ready=%b, want 0", i, pready[0]);
      end
    end
    psel[0] = 1'b0; penable[0] = 1'b0;
    @(negedge clk);
    model_xfer(0, 1'b0, 8'h00, 8'h00, xr, xe);
    xfer(0, 1'b0, 8'h00, 8'h00, w, rf, rd, er, ra, ea, rda);
    compared++;
    if (rd !== xr || rd !== 8'h00) begin
      mismatched++;
      $display("FAIL nosetup_read: rdata=%h, want %h", rd, xr);
    end
  endtask

  task automatic test_random();
    int w, k; bit wr; logic [7:0] a, d, rf, rd, rda, xr; logic er, ra, ea, xe;
    for (int i = 0; i < 80; i++) begin
      k  = int'($urandom_range(0, 2));
      wr = 1'($urandom_range(0, 1));
      a  = 8'($urandom);
      d  = 8'($urandom);
      model_xfer(k, wr, a, d, xr, xe);
      xfer(k, wr, a, d, w, rf, rd, er, ra, ea, rda);
      compared++;
      if (w !== ws_m[k] || er !== xe || rd !== xr) begin
        mismatched++;
        $display("FAIL rand[%0d] k=%0d wr=%b a=%h: waits=%0d err=%b rdata=%h, want %0d %b %h",
                 i, k, wr, a, w, er, rd, ws_m[k], xe, xr);
      end
      compared++;
      if (ra !== 1'b0 || ea !== 1'b0 || rda !== xr) begin
        mismatched++;
        $display("FAIL rand_post[%0d]: ready=%b err=%b rdata=%h, want 0 0 %h", i, ra, ea, rda, xr);
      end
      if ($urandom_range(0, 3) == 0) @(negedge clk);
    end
  endtask

  initial begin
    ws_m    = '{0, 2, 3};
    depth_m = '{256, 128, 256};
    test_reset();
    test_fill();
    test_basic();
    test_wait_states();
    test_error();
    test_abort();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, want completion");
    $fatal(1);
  end

endmodule
`default_nettype wire
